// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, taken-branch
// flushes and data-memory freezes with a timeout, plus saturating event counters.
module hazard_ctrl_unit #(
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idSrc1Reg,
  input  logic [4:0]       idSrc2Reg,
  input  logic             idUsesSrc2,
  input  logic             exeMemRead,
  input  logic [4:0]       exeDestReg,
  input  logic             exeBranchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexHold,
  output logic             idexBubble,
  output logic             exememHold,
  output logic             memwbBubble,
  output logic             memTimeout,
  output logic [CNT_W-1:0] loadStallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] memWaitCnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_ctr;
  logic [WAIT_W-1:0] wait_inc;
  logic              freeze, flush, load_use, wait_last;

  // memReq/memReady: an access started by MEM completes in the cycle memReady is
  // high while memReq is high; every cycle with memReq high and memReady low freezes.
  assign freeze    = memReq & ~memReady;
  assign flush     = exeBranchTaken & ~freeze;
  assign load_use  = exeMemRead && (exeDestReg != 5'd0) &&
                     ((exeDestReg == idSrc1Reg) || (idUsesSrc2 && (exeDestReg == idSrc2Reg)));
  assign wait_inc  = wait_ctr + 1'b1;
  assign wait_last = (wait_inc == WAIT_W'(MAX_WAIT));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_ctr     <= '0;
      loadStallCnt <= '0;
      flushCnt     <= '0;
      memWaitCnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state != ERROR) begin
        if (freeze) begin
          wait_ctr <= wait_inc;
          if (memWaitCnt != '1) memWaitCnt <= memWaitCnt + 1'b1;
        end else begin
          wait_ctr <= '0;
          if (flush) begin
            if (flushCnt != '1) flushCnt <= flushCnt + 1'b1;
          end else if (load_use) begin
            if (loadStallCnt != '1) loadStallCnt <= loadStallCnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, WAIT_MEM: begin
        if (freeze) state_nxt = wait_last ? ERROR : WAIT_MEM;
        else        state_nxt = RUN;
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexHold    = 1'b0;
    idexBubble  = 1'b0;
    exememHold  = 1'b0;
    memwbBubble = 1'b0;
    memTimeout  = (state == ERROR);
    if (rst) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
      memwbBubble = 1'b1;
    end else if (state == ERROR || freeze) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexHold    = 1'b1;
      exememHold  = 1'b1;
      memwbBubble = 1'b1;
    end else if (flush) begin
      ifidFlush   = 1'b1;
      idexBubble  = 1'b1;
    end else if (load_use) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexBubble  = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios and random traffic checked
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int CNT_W    = 4;
  localparam int WAIT_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       idSrc1Reg, idSrc2Reg, exeDestReg;
  logic             idUsesSrc2, exeMemRead, exeBranchTaken, memReq, memReady;
  logic             pcWrite, ifidWrite, ifidFlush, idexHold, idexBubble;
  logic             exememHold, memwbBubble, memTimeout;
  logic [CNT_W-1:0] loadStallCnt, flushCnt, memWaitCnt;
  logic [1:0]       state_dbg;

  int checks_total  = 0;
  int checks_passed = 0;

  // reference model: consecutive wait cycles, timeout flag, event counts
  int m_wait, m_ls, m_fl, m_mw;
  bit m_err;

  hazard_ctrl_unit #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .idSrc1Reg(idSrc1Reg), .idSrc2Reg(idSrc2Reg), .idUsesSrc2(idUsesSrc2),
    .exeMemRead(exeMemRead), .exeDestReg(exeDestReg), .exeBranchTaken(exeBranchTaken),
    .memReq(memReq), .memReady(memReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexHold(idexHold), .idexBubble(idexBubble), .exememHold(exememHold),
    .memwbBubble(memwbBubble), .memTimeout(memTimeout),
    .loadStallCnt(loadStallCnt), .flushCnt(flushCnt), .memWaitCnt(memWaitCnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // One cycle: drive inputs after negedge, check against model, model takes the posedge.
  task automatic step(input bit r, input logic [4:0] s1, input logic [4:0] s2, input bit u2,
                      input bit mr, input logic [4:0] d, input bit bt, input bit mq, input bit mrdy);
    bit         frz, lu;
    logic [7:0] exp_ctrl;
    logic [1:0] exp_state;
    @(negedge clk);
    rst = r; idSrc1Reg = s1; idSrc2Reg = s2; idUsesSrc2 = u2;
    exeMemRead = mr; exeDestReg = d; exeBranchTaken = bt; memReq = mq; memReady = mrdy;
    #1;
    frz = mq && !mrdy;
    lu  = mr && (d != 0) && ((d == s1) || (u2 && (d == s2)));
    // {pcWrite, ifidWrite, ifidFlush, idexHold, idexBubble, exememHold, memwbBubble, memTimeout}
    if (r)          exp_ctrl = {7'b0010101, m_err};
    else if (m_err) exp_ctrl = 8'b00010111;
    else if (frz)   exp_ctrl = 8'b00010110;
    else if (bt)    exp_ctrl = 8'b11101000;
    else if (lu)    exp_ctrl = 8'b00001000;
    else            exp_ctrl = 8'b11000000;
    exp_state = m_err ? 2'd2 : (m_wait > 0 ? 2'd1 : 2'd0);
    check("ctrl", {pcWrite, ifidWrite, ifidFlush, idexHold, idexBubble, exememHold,
                   memwbBubble, memTimeout}, 32'(exp_ctrl));
    check("state", 32'(state_dbg), 32'(exp_state));
    check("loadStallCnt", 32'(loadStallCnt), m_ls);
    check("flushCnt", 32'(flushCnt), m_fl);
    check("memWaitCnt", 32'(memWaitCnt), m_mw);
    if (r) begin
      m_wait = 0; m_err = 0; m_ls = 0; m_fl = 0; m_mw = 0;
    end else if (!m_err) begin
      if (frz) begin
        m_mw = sat_inc(m_mw);
        if (m_wait + 1 == MAX_WAIT) m_err = 1;
        else m_wait++;
      end else begin
        m_wait = 0;
        if (bt) m_fl = sat_inc(m_fl);
        else if (lu) m_ls = sat_inc(m_ls);
      end
    end
  endtask

  task automatic idle();
    step(0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_wait = 0; m_err = 0; m_ls = 0; m_fl = 0; m_mw = 0;
    rst = 1'b1; idSrc1Reg = '0; idSrc2Reg = '0; idUsesSrc2 = 0; exeMemRead = 0;
    exeDestReg = '0; exeBranchTaken = 0; memReq = 0; memReady = 0;
    repeat (2) @(posedge clk);
    do_reset();
    idle();
    check("reset_counters", 32'({loadStallCnt, flushCnt, memWaitCnt}), 32'd0);

    // load r5 in EXE, ID reads rs=5
    step(0, 5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle();
    check("lu_rs_count", 32'(loadStallCnt), 32'd1);
    // load into r0 never stalls
    do_reset();
    step(0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("lu_r0_count", 32'(loadStallCnt), 32'd0);
    // rt match only counts when rt is a source
    step(0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    idle();
    check("lu_rt_unused", 32'(loadStallCnt), 32'd0);
    step(0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    idle();
    check("lu_rt_used", 32'(loadStallCnt), 32'd1);
    // branch beats load-use
    do_reset();
    step(0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle();
    check("br_counts", 32'({flushCnt, loadStallCnt}), 32'({4'd1, 4'd0}));
    // three-cycle memory wait, then ready
    do_reset();
    repeat (3) step(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    check("wait_count", 32'(memWaitCnt), 32'd3);
    check("wait_run", 32'(state_dbg), 32'd0);
    // timeout after MAX_WAIT cycles, then reset recovers
    do_reset();
    repeat (MAX_WAIT) step(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("timeout_flag", 32'(memTimeout), 32'd1);
    check("timeout_frozen", 32'({flushCnt, memWaitCnt}), 32'({4'd0, 4'(MAX_WAIT)}));
    do_reset();
    idle();
    check("recover", 32'({memTimeout, state_dbg, loadStallCnt, flushCnt, memWaitCnt}), 32'd0);
    // saturation
    repeat (CNT_MAX + 2) step(0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    idle();
    check("saturate", 32'(loadStallCnt), CNT_MAX);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), d, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
